// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with a one-entry holding buffer.
// Bit order is latched per word; back-to-back words stream without a gap.
module piso_serializer #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             msb_first,
    input  logic             shift_enable,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             bit_first,
    output logic             bit_last,
    output logic             busy
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [0:0]       state;
    logic [WIDTH-1:0] hold_data;
    logic             hold_msb;
    logic             hold_full;
    logic [WIDTH-1:0] shreg;
    logic             order;
    logic [CNT_W-1:0] count;

    logic in_shift;
    logic at_last;
    logic accept;
    logic advance;
    logic take;

    assign in_shift = (state == SHIFT);
    assign at_last  = (count == LAST);
    assign accept   = load_valid && !hold_full;
    assign advance  = in_shift && shift_enable;
    // hold feeds the shifter when idle, or on the final bit of a frame
    assign take     = hold_full && (!in_shift || (advance && at_last));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            hold_data <= '0;
            hold_msb  <= 1'b0;
            hold_full <= 1'b0;
            shreg     <= '0;
            order     <= 1'b0;
            count     <= '0;
        end else begin
            if (accept) begin
                hold_data <= data_in;
                hold_msb  <= msb_first;
                hold_full <= 1'b1;
            end else if (take) begin
                hold_full <= 1'b0;
            end

            if (take) begin
                shreg <= hold_data;
                order <= hold_msb;
                count <= '0;
                state <= SHIFT;
            end else if (advance) begin
                if (at_last) begin
                    state <= IDLE;
                end else begin
                    shreg <= order ? (shreg << 1) : (shreg >> 1);
                    count <= count + 1'b1;
                end
            end
        end
    end

    assign load_ready   = !hold_full;
    assign serial_valid = in_shift;
    assign serial_out   = in_shift && (order ? shreg[WIDTH-1] : shreg[0]);
    assign bit_first    = in_shift && (count == '0);
    assign bit_last     = in_shift && at_last;
    assign busy         = in_shift || hold_full;

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter. It is the companion to the team's serial-in universal shift register.
- Accepts a WIDTH-bit word over a valid/ready handshake and holds it in a one-entry buffer.
- Shifts the word out one bit per enabled clock, MSB-first or LSB-first. The order is chosen per word.
- Feeds the serial input of the receive-side shift register. Back-to-back words stream with no idle gap.

Parameters:
- WIDTH, 8, word width in bits; legal range WIDTH >= 2.
- CNT_W, $clog2(WIDTH), width of the internal bit counter; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- load_valid  input  1  producer presents a word on data_in.
- load_ready  output  1  holding buffer can accept a word.
- data_in  input  WIDTH  parallel word to transmit.
- msb_first  input  1  bit order for the word on data_in; 1 = MSB first, 0 = LSB first. Sampled together with data_in.
- shift_enable  input  1  bit-rate strobe; the shifter advances only on edges where this is 1.
- serial_out  output  1  current serial bit.
- serial_valid  output  1  serial_out carries a word bit.
- bit_first  output  1  current bit is bit 0 of the frame.
- bit_last  output  1  current bit is bit WIDTH-1 of the frame.
- busy  output  1  the shifter or the holding buffer is occupied.

Behaviour:
- Reset (reset==0 at a rising edge):
  - The holding buffer, shift register, counter and state are cleared.
  - Next cycle: load_ready=1, serial_out=0, serial_valid=0, bit_first=0, bit_last=0, busy=0.
  - Reset overrides every other input. A word partly shifted or buffered is discarded, with no partial completion.
- Handshake:
  - A transfer happens on an edge where load_valid && load_ready.
  - data_in and msb_first are captured into the holding buffer (hold_full=1).
  - load_ready = !hold_full. It is registered-state derived and has no combinational path from load_valid.
  - load_valid while load_ready==0 has no effect. The producer keeps data stable until accepted.
- State machine, two states:
  - IDLE: serial_valid=0, serial_out=0. On any edge with hold_full=1, load the shift register and order bit from hold, set hold_full=0, set count=0, and go to SHIFT. This does not wait for shift_enable.
  - SHIFT: serial_valid=1.
    - serial_out = shreg[WIDTH-1] if the order bit is 1, else shreg[0].
    - bit_first = (count==0). bit_last = (count==WIDTH-1).
- Advance in SHIFT: on an edge with shift_enable=1 and count<WIDTH-1, shift toward the output end (zero fill) and increment count.
- Stall: shift_enable=0 holds serial_out, count and the flags unchanged for any number of cycles.
- Last-bit edge (SHIFT, count==WIDTH-1, shift_enable=1):
  - If hold_full=1: load the next word from hold, clear hold_full, set count=0, and stay in SHIFT. The first bit of the new word appears the next cycle with no gap.
  - Else: go to IDLE.
- Simultaneous events:
  - On the same edge, a hold-to-shifter move and a new accept can both happen only if hold_full was 0 at the start. Since load_ready=0 while hold_full=1, at most one word enters hold per edge.
  - Accepting into an empty hold on the same edge as a shifter load from hold cannot occur.
- Latency: a word accepted at edge N with the shifter idle is loaded at edge N+1. Its first bit is valid in the cycle after N+1.
- busy = (state==SHIFT) || hold_full.
- Throughput: with shift_enable held at 1, one bit per cycle, continuous across words while the producer keeps hold filled.
- Order is per word: msb_first is latched with each word, so changing it mid-frame does not affect the word being shifted.

Test Plan:
- Reset check: drive reset=0 for 2 cycles with load_valid=1 -> load_ready=1, serial_valid=0, serial_out=0, busy=0 after release; no word captured while in reset.
- MSB-first single word: data_in=8'hB4, msb_first=1, shift_enable=1 -> serial_out 1,0,1,1,0,1,0,0 over 8 consecutive cycles. bit_first on bit 1, bit_last on bit 8. Return to IDLE, busy=0.
- LSB-first single word: 8'hB4, msb_first=0 -> serial_out 0,0,1,0,1,1,0,1. Toggling msb_first mid-frame does not change the sequence.
- Back-to-back: offer 8'hFF then 8'h00 (msb_first=1) continuously -> 16 contiguous valid bits (eight 1s, then eight 0s). bit_last of word 1 is immediately followed by bit_first of word 2. load_ready deasserts while hold_full.
- Stall: shift_enable pattern 1,0,0,1,1,... on 8'hA5 -> serial_out and count frozen during the 0 cycles. The bit sequence is 1,0,1,0,0,1,0,1 with no bit lost or repeated.
- Reset mid-operation: assert reset=0 after 3 bits of 8'hC3 with a second word in hold -> next cycle all outputs are at reset values. Neither word resumes after release. A fresh word after release transmits correctly.
